// File: rtl/alu_operand_stage_if.sv
// ID -> ID/EX -> EX/MEM handshake bundle for the ALU operand stage.
// master = ID side driving instructions and EX/MEM ready; slave = the operand stage itself.
interface alu_operand_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int FW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [AW-1:0] in_rs_addr;
  logic [AW-1:0] in_rt_addr;
  logic [DW-1:0] in_rs_data;
  logic [DW-1:0] in_rt_data;
  logic [DW-1:0] in_imm;
  logic          in_alusrc_imm;
  logic          in_uses_rt;
  logic [FW-1:0] in_alufun;
  logic          in_sign;
  logic [AW-1:0] in_rd_addr;
  logic          in_regwrite;
  logic          in_memread;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [FW-1:0] alu_fun;
  logic          alu_sign;
  logic [DW-1:0] out_pc;
  logic [AW-1:0] out_rd_addr;
  logic          out_regwrite;
  logic          out_memread;

  modport master (
    output in_valid, in_pc, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data, in_imm,
           in_alusrc_imm, in_uses_rt, in_alufun, in_sign, in_rd_addr, in_regwrite,
           in_memread, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_fun, alu_sign, out_pc, out_rd_addr,
           out_regwrite, out_memread
  );

  modport slave (
    input  in_valid, in_pc, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data, in_imm,
           in_alusrc_imm, in_uses_rt, in_alufun, in_sign, in_rd_addr, in_regwrite,
           in_memread, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_fun, alu_sign, out_pc, out_rd_addr,
           out_regwrite, out_memread
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU with EX/MEM + MEM/WB forwarding; load-use stall under ALU_OPERAND_STAGE_LOAD_USE_EN.
// Latency 1; single entry, back-to-back when out_ready is high, holds and snoops writebacks otherwise.
module alu_operand_stage #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          reset,
  alu_operand_stage_if.slave bus,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic          hazard_stall
);

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] rd_addr;
    logic          alusrc_imm;
    logic          regwrite;
    logic          memread;
    logic          sign;
    logic [FW-1:0] alufun;
  } entry_t;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  entry_t ent;
  entry_t ent_nxt;

  logic capture;
  logic wb_rs_in_hit, wb_rt_in_hit;
  logic wb_rs_hit, wb_rt_hit;
  logic ex_rs_hit, ex_rt_hit;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Reset also gates in_ready so nothing is accepted while the stage is being cleared.
  assign bus.in_ready = !reset && !flush && !hazard_stall && (state == EMPTY || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  assign wb_rs_in_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == bus.in_rs_addr);
  assign wb_rt_in_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == bus.in_rt_addr);
  assign wb_rs_hit    = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ent.rs_addr);
  assign wb_rt_hit    = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ent.rt_addr);
  assign ex_rs_hit    = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ent.rs_addr);
  assign ex_rt_hit    = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ent.rt_addr);

  always_comb begin
    ent_nxt            = '0;
    ent_nxt.pc         = bus.in_pc;
    ent_nxt.rs_data    = wb_rs_in_hit ? memwb_data : bus.in_rs_data;
    ent_nxt.rt_data    = wb_rt_in_hit ? memwb_data : bus.in_rt_data;
    ent_nxt.imm        = bus.in_imm;
    ent_nxt.rs_addr    = bus.in_rs_addr;
    ent_nxt.rt_addr    = bus.in_rt_addr;
    ent_nxt.rd_addr    = bus.in_rd_addr;
    ent_nxt.alusrc_imm = bus.in_alusrc_imm;
    ent_nxt.regwrite   = bus.in_regwrite;
    ent_nxt.memread    = bus.in_memread;
    ent_nxt.sign       = bus.in_sign;
    ent_nxt.alufun     = bus.in_alufun;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      ent   <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (capture) begin
      state <= FULL;
      ent   <= ent_nxt;
    end else if (state == FULL) begin
      if (bus.out_ready) begin
        state <= EMPTY;
      end else begin
        // Held entry must not go stale when its source register retires meanwhile.
        if (wb_rs_hit) ent.rs_data <= memwb_data;
        if (wb_rt_hit) ent.rt_data <= memwb_data;
      end
    end
  end

  always_comb begin
    fwd_rs = ent.rs_data;
    if (ex_rs_hit)      fwd_rs = exmem_data;
    else if (wb_rs_hit) fwd_rs = memwb_data;
    fwd_rt = ent.rt_data;
    if (ex_rt_hit)      fwd_rt = exmem_data;
    else if (wb_rt_hit) fwd_rt = memwb_data;
  end

  assign bus.out_valid    = (state == FULL);
  assign bus.alu_a        = fwd_rs;
  assign bus.alu_b        = ent.alusrc_imm ? ent.imm : fwd_rt;
  assign bus.alu_fun      = ent.alufun;
  assign bus.alu_sign     = ent.sign;
  assign bus.out_pc       = ent.pc;
  assign bus.out_rd_addr  = ent.rd_addr;
  assign bus.out_regwrite = ent.regwrite;
  assign bus.out_memread  = ent.memread;

`ifdef ALU_OPERAND_STAGE_LOAD_USE_EN
  assign hazard_stall = (state == FULL) && ent.memread && ent.regwrite && (ent.rd_addr != '0) &&
                        bus.in_valid &&
                        ((bus.in_rs_addr == ent.rd_addr) ||
                         (bus.in_uses_rt && (bus.in_rt_addr == ent.rd_addr)));
`else
  logic unused_uses_rt;
  assign unused_uses_rt = bus.in_uses_rt;
  assign hazard_stall   = 1'b0;
`endif

endmodule
